// File: rtl/ahb_subordinate_mem_pkg.sv
// ahb_subordinate_mem_pkg: shared AHB enums, wait-counter width and size-to-lane mask helper
package ahb_subordinate_mem_pkg;
  typedef enum logic [1:0] {AHB_IDLE, AHB_BUSY, AHB_NONSEQ, AHB_SEQ} ahbTransferEnum;
  typedef enum logic [2:0] {
    HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
    HSIZE_4WORD, HSIZE_8WORD, HSIZE_16WORD, HSIZE_32WORD
  } ahbHsizeEnum;
  typedef enum logic {RESP_OKAY, RESP_ERROR} ahbRespEnum;
  typedef enum logic [1:0] {SUB_IDLE, SUB_WAIT, SUB_ERR1, SUB_ERR2} ahbSubStateEnum;
  localparam int AHB_WAIT_CNT_WIDTH = 4;
  function automatic logic [3:0] ahbLaneMask(input logic [2:0] hsize, input logic [1:0] addr);
    return hsize == HSIZE_BYTE ? 4'b0001 << addr :
           hsize == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_subordinate_mem_mem_array.sv
// ahb_sub_mem_array: word RAM with byte write enables and a write-first synchronous read port
module ahb_sub_mem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  // a read colliding with a commit to the same word sees the freshly written bytes
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re)
      for (int b = 0; b < 4; b++)
        rdata[8*b +: 8] <= (we[b] && waddr == raddr) ? wdata[8*b +: 8] : mem[raddr][8*b +: 8];
endmodule

// File: rtl/ahb_subordinate_mem.sv
// ahb_subordinate_mem: AHB subordinate with byte-enabled word memory, programmable waits and ERROR response
module ahb_subordinate_mem
  import ahb_subordinate_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter int                    HPROT_WIDTH   = 4
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [HPROT_WIDTH-1:0]  hprot,
  input  logic                    hmastlock,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic [3:0]              cfg_wait_states,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);
  localparam int WA = MEM_ADDR_BITS - 2;
  ahbSubStateEnum                state;
  logic [AHB_WAIT_CNT_WIDTH-1:0] cnt;
  logic                          pend_wr;
  logic [WA-1:0]                 waddr;
  logic [3:0]                    lane;
  logic [ADDR_WIDTH-1:0]         off;
  logic                          borrow, accept, misalign, err;
  logic [3:0]                    we;
  logic                          unused_ok;
  assign {borrow, off} = {1'b0, haddr} - {1'b0, BASE_ADDR};
  assign accept   = hselx && hready && htrans[1];
  assign misalign = (hsize == HSIZE_HALF && haddr[0]) || (hsize == HSIZE_WORD && |haddr[1:0]);
  assign err      = borrow || |off[ADDR_WIDTH-1:MEM_ADDR_BITS] || hsize > HSIZE_WORD || misalign;
  assign we       = {4{pend_wr && hreadyout && !hreset}} & hwstrb & lane;
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], off[1:0]};
  always_ff @(posedge hclk)
    if (hreset) begin
      state     <= SUB_IDLE;
      cnt       <= '0;
      pend_wr   <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= RESP_OKAY;
    end else begin
      if (hreadyout) pend_wr <= 1'b0;
      case (state)
        SUB_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == AHB_WAIT_CNT_WIDTH'(1)) begin
            state     <= SUB_IDLE;
            hreadyout <= 1'b1;
          end
        end
        SUB_ERR1: begin
          state     <= SUB_ERR2;
          hreadyout <= 1'b1;
        end
        default: begin
          state     <= !accept ? SUB_IDLE : err ? SUB_ERR1 : cfg_wait_states != 0 ? SUB_WAIT : SUB_IDLE;
          hreadyout <= !accept || (!err && cfg_wait_states == 0);
          hresp     <= accept && err;
          if (accept) begin
            cnt     <= cfg_wait_states;
            pend_wr <= hwrite && !err;
            waddr   <= off[MEM_ADDR_BITS-1:2];
            lane    <= ahbLaneMask(hsize, haddr[1:0]);
          end
        end
      endcase
    end
  ahb_sub_mem_array #(.AW(WA)) u_mem (
    .clk   (hclk),
    .rst   (hreset),
    .we    (we),
    .waddr (waddr),
    .wdata (hwdata),
    .re    (accept && !hwrite && !err),
    .raddr (off[MEM_ADDR_BITS-1:2]),
    .rdata (hrdata)
  );
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// tb_ahb_subordinate_mem: directed scenarios for the AHB memory subordinate with hand-computed expectations
module tb_ahb_subordinate_mem;
  logic        hclk, hreset, hselx, hwrite, hmastlock, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot, hwstrb, cfg_wait_states;
  logic        hreadyout, hresp;
  int          n_checks = 0;
  int          n_fail = 0;

  ahb_subordinate_mem dut (
    .hclk(hclk), .hreset(hreset), .hselx(hselx), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready), .cfg_wait_states(cfg_wait_states),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  assign hready = hreadyout;
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hselx = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic set_idle();
    htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic [3:0] s);
    set_addr(1'b1, a, sz);
    @(negedge hclk);
    hwdata = d; hwstrb = s; set_idle();
    @(negedge hclk);
  endtask

  task automatic rd0(input logic [31:0] a);
    set_addr(1'b0, a, 3'b010);
    @(negedge hclk);
    set_idle();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (2) @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout); end
    n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
    n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 00000000", hrdata); end
    hreset = 1'b0;
    @(negedge hclk);
  endtask

  task automatic test_basic();
    set_addr(1'b1, 32'h10, 3'b010);
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL basic_wr_phase: got ready=%b resp=%b expected 1/0", hreadyout, hresp); end
    hwdata = 32'hDEADBEEF; hwstrb = 4'hF; set_idle();
    @(negedge hclk);
    rd0(32'h10);
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL basic_rd_phase: got ready=%b resp=%b expected 1/0", hreadyout, hresp); end
    n_checks++; if (hrdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rdata: got %h expected deadbeef", hrdata); end
  endtask

  task automatic test_wait_states();
    int n = 0;
    cfg_wait_states = 4'd3;
    set_addr(1'b0, 32'h10, 3'b010);
    @(negedge hclk);
    set_idle();
    cfg_wait_states = 4'd0;
    while (hreadyout === 1'b0 && n < 20) begin
      n++;
      @(negedge hclk);
    end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL wait_low_cycles: got %0d expected 3", n); end
    n_checks++; if (hrdata !== 32'hDEADBEEF || hresp !== 1'b0) begin n_fail++; $display("FAIL wait_rdata: got %h resp=%b expected deadbeef resp=0", hrdata, hresp); end
  endtask

  task automatic test_byte_and_misalign();
    wr0(32'h12, 3'b000, 32'h11A52233, 4'h4);
    rd0(32'h10);
    n_checks++; if (hrdata !== 32'hDEA5BEEF) begin n_fail++; $display("FAIL byte_merge: got %h expected dea5beef", hrdata); end
    set_addr(1'b1, 32'h11, 3'b001);
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL misalign_err1: got ready=%b resp=%b expected 0/1", hreadyout, hresp); end
    hwdata = 32'hFFFFFFFF; hwstrb = 4'hF; set_idle();
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL misalign_err2: got ready=%b resp=%b expected 1/1", hreadyout, hresp); end
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL misalign_after: got ready=%b resp=%b expected 1/0", hreadyout, hresp); end
    rd0(32'h10);
    n_checks++; if (hrdata !== 32'hDEA5BEEF) begin n_fail++; $display("FAIL misalign_nowrite: got %h expected dea5beef", hrdata); end
  endtask

  task automatic test_out_of_range();
    set_addr(1'b0, 32'h1000, 3'b010);
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL oor_err1: got ready=%b resp=%b expected 0/1", hreadyout, hresp); end
    set_idle();
    @(negedge hclk);
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL oor_err2: got ready=%b resp=%b expected 1/1", hreadyout, hresp); end
    n_checks++; if (hrdata !== 32'hDEA5BEEF) begin n_fail++; $display("FAIL oor_hold: got %h expected dea5beef", hrdata); end
    @(negedge hclk);
    wr0(32'h1010, 3'b010, 32'h00000000, 4'hF);
    @(negedge hclk);
    rd0(32'h10);
    n_checks++; if (hrdata !== 32'hDEA5BEEF) begin n_fail++; $display("FAIL oor_mem_unchanged: got %h expected dea5beef", hrdata); end
  endtask

  task automatic test_back_to_back();
    set_addr(1'b1, 32'h20, 3'b010);
    @(negedge hclk);
    hwdata = 32'h12345678; hwstrb = 4'hF;
    set_addr(1'b0, 32'h20, 3'b010);
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b expected 1", hreadyout); end
    @(negedge hclk);
    n_checks++; if (hrdata !== 32'h12345678 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL b2b_forward: got %h ready=%b expected 12345678 ready=1", hrdata, hreadyout); end
    set_addr(1'b0, 32'h10, 3'b010);
    @(negedge hclk);
    set_addr(1'b0, 32'h20, 3'b010);
    n_checks++; if (hrdata !== 32'hDEA5BEEF) begin n_fail++; $display("FAIL b2b_rd1: got %h expected dea5beef", hrdata); end
    @(negedge hclk);
    set_idle();
    n_checks++; if (hrdata !== 32'h12345678 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL b2b_rd2: got %h ready=%b expected 12345678 ready=1", hrdata, hreadyout); end
    @(negedge hclk);
  endtask

  task automatic test_mid_reset();
    wr0(32'h30, 3'b010, 32'h0BADF00D, 4'hF);
    cfg_wait_states = 4'd2;
    set_addr(1'b1, 32'h30, 3'b010);
    @(negedge hclk);
    hwdata = 32'hFFFFFFFF; hwstrb = 4'hF; set_idle();
    n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL midrst_wait: got ready=%b expected 0", hreadyout); end
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    cfg_wait_states = 4'd0;
    n_checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got ready=%b resp=%b expected 1/0", hreadyout, hresp); end
    @(negedge hclk);
    rd0(32'h30);
    n_checks++; if (hrdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL midrst_nocommit: got %h expected 0badf00d", hrdata); end
  endtask

  initial begin
    hreset = 1'b1; hselx = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
    hburst = 3'b000; hprot = 4'h3; hmastlock = 1'b0; hwdata = '0; hwstrb = '0; cfg_wait_states = 4'd0;
    test_reset();
    test_basic();
    test_wait_states();
    test_byte_and_misalign();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_subordinate_mem.md
Name: ahb_subordinate_mem

Overview:
- Synthesizable AHB subordinate (responder) RTL with a byte-enabled word memory.
- Serves as the DUT-side endpoint driven by the manager agents.
- Decodes the address/control phase and inserts programmable wait states.
- Performs byte/halfword/word reads and writes, and returns the two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; fixed at 32 for this block.
- BASE_ADDR, 32'h0000_0000, lowest decoded byte address.
- MEM_ADDR_BITS, 12, memory holds 2**MEM_ADDR_BITS bytes.
- HPROT_WIDTH, 4, hprot width.

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hreset  input  1  synchronous active-high reset.
- hselx  input  1  subordinate select from decoder.
- haddr  input  ADDR_WIDTH  transfer address.
- htrans  input  2  IDLE/BUSY/NONSEQ/SEQ.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  transfer size.
- hburst  input  3  burst type; informational only.
- hprot  input  HPROT_WIDTH  protection; ignored.
- hmastlock  input  1  lock; ignored.
- hwdata  input  DATA_WIDTH  write data, data phase.
- hwstrb  input  DATA_WIDTH/8  write byte strobes, data phase.
- hready  input  1  combined bus ready.
- cfg_wait_states  input  4  wait states per accepted transfer.
- hrdata  output  DATA_WIDTH  read data.
- hreadyout  output  1  subordinate ready.
- hresp  output  1  0=OKAY, 1=ERROR.

Behaviour:
- Clock and reset: one clock, hclk. Reset hreset is synchronous and active-high.
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, pending-write flag=0. Memory contents are not reset.
- Accept condition: an address phase is accepted on a rising edge with hselx && hready && htrans[1]=1 (NONSEQ or SEQ).
  - IDLE or BUSY with hselx && hready: zero-wait OKAY, no memory access.
- Error check, evaluated at accept. Any one of these flags an error:
  - haddr outside [BASE_ADDR, BASE_ADDR+2**MEM_ADDR_BITS-1].
  - hsize > WORD.
  - haddr not aligned to hsize.
- FSM states and transitions:
  - IDLE: hreadyout=1, hresp=0.
  - Accept with error → ERR1.
  - Accept OK with cfg_wait_states=0 → IDLE; the data phase completes next cycle with hreadyout=1.
  - Accept OK with cfg_wait_states=N>0 → WAIT, counter loaded with N.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; on reaching 1 → IDLE, so the next cycle has hreadyout=1. Exactly N low cycles.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept in ERR2 is treated as from IDLE. No memory access is performed for errored transfers.
- Latency: data phase length is 1+cfg_wait_states cycles. cfg_wait_states is sampled only at accept; mid-transfer changes are ignored.
- Write path:
  - Address, size and lane are registered at accept.
  - hwdata/hwstrb are sampled on the final data-phase edge (hreadyout=1).
  - Byte lanes written = hwstrb AND the size lane mask derived from haddr[1:0]/hsize.
- Read path:
  - hrdata is registered with the full 32-bit word at word index (haddr-BASE_ADDR)>>2.
  - It is valid while hreadyout=1 in the final data cycle and holds its value otherwise.
  - Unaddressed lanes return memory contents; no zeroing.
- Read-after-write hazard: if a read accept coincides with the commit edge of a write to the same word, hrdata returns the merged (new) bytes.
- Pipelining: back-to-back NONSEQ/SEQ transfers sustain one transfer per cycle at zero wait states.
- Burst addressing comes from the manager on every beat; there is no internal address increment or wrap.
- Mid-reset: a synchronous reset during WAIT/ERR1/ERR2 or a pending data phase aborts the transfer. The pending write is not committed.

Decomposition:
- Shared package gets:
  - Existing ahbTransferEnum, ahbHsizeEnum, ahbRespEnum.
  - New constants AHB_WAIT_CNT_WIDTH=4 and size-to-lane-mask function ahbLaneMask(hsize, addr[1:0]).
  - FSM enum ahbSubStateEnum {SUB_IDLE, SUB_WAIT, SUB_ERR1, SUB_ERR2}.
- Sub-module ahb_sub_mem_array: 2**(MEM_ADDR_BITS-2) x 32 word RAM with a 4-bit byte write enable and a synchronous read port.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x10 (WORD, hwstrb=4'hF, 0 waits) and read 0x10 → hreadyout=1 both data phases, hresp=0, hrdata=32'hDEADBEEF.
- cfg_wait_states=3, read 0x10 → hreadyout low exactly 3 cycles, then high with hrdata=32'hDEADBEEF.
- Write BYTE 8'hA5 to 0x12 (hwstrb=4'h4) and read 0x10 → hrdata=32'hDEA5BEEF. A HALFWORD write to 0x11 → ERROR (misaligned).
- Read 0x1000 (out of range) → one cycle hreadyout=0,hresp=1, then one cycle hreadyout=1,hresp=1; memory unchanged.
- Back-to-back write 0x20=32'h12345678 then immediate read 0x20, 0 waits → read returns 32'h12345678 (forwarding).
- Assert hreset during a WAIT cycle of a write to 0x30 → next cycle hreadyout=1,hresp=0; a later read of 0x30 returns the prior contents.
